// File: rtl/int_to_float_stream_if.sv
// Valid/ready stream bundle for int_to_float_stream.
// Carries out_inexact only when INT_TO_FLOAT_INEXACT_FLAG_EN is defined.
interface int_to_float_stream_if #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 32
);
    localparam int FW = 1 + EXPONENT_SIZE + MANTISSA_SIZE;

    logic                in_valid;
    logic                in_ready;
    logic [INT_SIZE-1:0] in_data;
    logic                in_signed;
    logic                out_valid;
    logic                out_ready;
    logic [FW-1:0]       out_data;
`ifdef INT_TO_FLOAT_INEXACT_FLAG_EN
    logic                out_inexact;

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );
`else
    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data
    );
    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/int_to_float_stream.sv
// 4-stage pipelined integer to IEEE-style float converter, round to nearest even.
// Define INT_TO_FLOAT_INEXACT_FLAG_EN to add the out_inexact flag.
module int_to_float_stream #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    int_to_float_stream_if.slave  bus
);
    localparam int M    = MANTISSA_SIZE;
    localparam int E    = EXPONENT_SIZE;
    localparam int N    = INT_SIZE;
    localparam int FW   = 1 + E + M;
    localparam int PW   = $clog2(N);
    localparam int NW   = N + M + 2;
    localparam int BIAS = (1 << (E - 1)) - 1;

    logic          adv;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_sign_q, s1_sign_d;
    logic [N-1:0]  s1_mag_q, s1_mag_d;

    logic          s2_valid_q, s2_valid_d;
    logic          s2_sign_q, s2_sign_d;
    logic [N-1:0]  s2_mag_q, s2_mag_d;
    logic [PW-1:0] s2_p_q, s2_p_d;

    logic          s3_valid_q, s3_valid_d;
    logic          s3_sign_q, s3_sign_d;
    logic          s3_nz_q, s3_nz_d;
    logic [PW-1:0] s3_p_q, s3_p_d;
    logic [M-1:0]  s3_mant_q, s3_mant_d;
    logic          s3_g_q, s3_g_d;
    logic          s3_r_q, s3_r_d;
    logic          s3_s_q, s3_s_d;

    logic          s4_valid_q, s4_valid_d;
    logic [FW-1:0] s4_data_q, s4_data_d;
`ifdef INT_TO_FLOAT_INEXACT_FLAG_EN
    logic          s4_inexact_q, s4_inexact_d;
`endif

    logic [PW-1:0] shamt;
    logic [NW-1:0] ext;
    logic          rnd_up;
    logic [M:0]    sum;
    logic [E-1:0]  exp_w;

    // The whole pipe advances together; bubbles hold in place too
    assign adv           = !s4_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = s4_valid_q;
    assign bus.out_data  = s4_data_q;
`ifdef INT_TO_FLOAT_INEXACT_FLAG_EN
    assign bus.out_inexact = s4_inexact_q;
`endif

    always_comb begin
        s1_valid_d = bus.in_valid;
        s1_sign_d  = bus.in_signed & bus.in_data[N-1];
        s1_mag_d   = s1_sign_d ? -bus.in_data : bus.in_data;
    end

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_sign_d  = s1_sign_q;
        s2_mag_d   = s1_mag_q;
        s2_p_d     = '0;
        for (int i = 0; i < N; i++) begin
            if (s1_mag_q[i]) s2_p_d = PW'(i);
        end
    end

    // Hidden bit lands at ext[NW-1]; it is clear only for a zero magnitude
    always_comb begin
        shamt      = PW'(N - 1) - s2_p_q;
        ext        = {s2_mag_q, {(M + 2){1'b0}}} << shamt;
        s3_valid_d = s2_valid_q;
        s3_sign_d  = s2_sign_q;
        s3_p_d     = s2_p_q;
        s3_nz_d    = ext[NW-1];
        s3_mant_d  = ext[NW-2 -: M];
        s3_g_d     = ext[N];
        s3_r_d     = ext[N-1];
        s3_s_d     = |ext[N-2:0];
    end

    // A mantissa carry-out wraps sum[M-1:0] to zero and bumps the exponent
    always_comb begin
        rnd_up     = s3_g_q & (s3_r_q | s3_s_q | s3_mant_q[0]);
        sum        = {1'b0, s3_mant_q} + {{M{1'b0}}, rnd_up};
        exp_w      = E'(s3_p_q) + E'(BIAS) + E'(sum[M]);
        s4_valid_d = s3_valid_q;
        s4_data_d  = '0;
        if (s3_nz_q) s4_data_d = {s3_sign_q, exp_w, sum[M-1:0]};
`ifdef INT_TO_FLOAT_INEXACT_FLAG_EN
        s4_inexact_d = s3_g_q | s3_r_q | s3_s_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_mag_q   <= '0;
            s2_p_q     <= '0;
            s3_valid_q <= 1'b0;
            s3_sign_q  <= 1'b0;
            s3_nz_q    <= 1'b0;
            s3_p_q     <= '0;
            s3_mant_q  <= '0;
            s3_g_q     <= 1'b0;
            s3_r_q     <= 1'b0;
            s3_s_q     <= 1'b0;
            s4_valid_q <= 1'b0;
            s4_data_q  <= '0;
`ifdef INT_TO_FLOAT_INEXACT_FLAG_EN
            s4_inexact_q <= 1'b0;
`endif
        end else if (adv) begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_mag_q   <= s2_mag_d;
            s2_p_q     <= s2_p_d;
            s3_valid_q <= s3_valid_d;
            s3_sign_q  <= s3_sign_d;
            s3_nz_q    <= s3_nz_d;
            s3_p_q     <= s3_p_d;
            s3_mant_q  <= s3_mant_d;
            s3_g_q     <= s3_g_d;
            s3_r_q     <= s3_r_d;
            s3_s_q     <= s3_s_d;
            s4_valid_q <= s4_valid_d;
            s4_data_q  <= s4_data_d;
`ifdef INT_TO_FLOAT_INEXACT_FLAG_EN
            s4_inexact_q <= s4_inexact_d;
`endif
        end
    end
endmodule
